// File: rtl/ifu_fetch_buf.sv
// Instruction fetch stage: one outstanding imem request at a time, returned {pc,inst}
// pairs queued in a small FIFO toward decode; a redirect flushes and restarts fetch.
module ifu_fetch_buf #(
    parameter int unsigned       XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = 32'h8000_0000,
    parameter int unsigned       DEPTH    = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] inst_pc_o
);
    localparam int unsigned     PW      = $clog2(DEPTH);
    localparam logic [PW:0]     CNT_MAX = (PW+1)'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    state_t          r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pend_pc;
    logic [PW:0]     r_count;
    logic [PW-1:0]   r_wptr, r_rptr;
    logic [XLEN-1:0] r_mem_pc   [DEPTH];
    logic [31:0]     r_mem_inst [DEPTH];
    logic            w_req_valid, w_req_fire, w_inst_valid, w_push, w_pop;
    logic            w_unused_pc_lsbs;

    // A slot is reserved at acceptance, so a request is only issued while count < DEPTH.
    assign w_req_valid  = (r_state == S_REQ) && (r_count < CNT_MAX) && !rst_i;
    assign w_req_fire   = w_req_valid && imem_req_ready_i;
    assign w_inst_valid = (r_count != '0) && !rst_i;
    assign w_push       = (r_state == S_WAIT) && imem_rsp_valid_i && !redirect_i;
    assign w_pop        = w_inst_valid && inst_ready_i && !redirect_i;
    assign w_unused_pc_lsbs = ^redirect_pc_i[1:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_REQ: begin
                if (w_req_fire) w_state_nxt = redirect_i ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (imem_rsp_valid_i)  w_state_nxt = S_REQ;
                else if (redirect_i)   w_state_nxt = S_DROP;
            end
            S_DROP: begin
                if (imem_rsp_valid_i)  w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (redirect_i)      r_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
            else if (w_req_fire) r_pc <= r_pc + PC_STEP;
            // Redirect flushes the queue; a simultaneous pop is ignored.
            if (redirect_i) begin
                r_count <= '0;
                r_wptr  <= '0;
                r_rptr  <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + PW'(1);
                if (w_pop)  r_rptr <= r_rptr + PW'(1);
                r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_req_fire) r_pend_pc <= r_pc;
        if (w_push) begin
            r_mem_pc[r_wptr]   <= r_pend_pc;
            r_mem_inst[r_wptr] <= imem_rsp_data_i;
        end
    end

    assign imem_req_valid_o = w_req_valid;
    assign imem_req_addr_o  = r_pc;
    assign inst_valid_o     = w_inst_valid;
    assign inst_o           = r_mem_inst[r_rptr];
    assign inst_pc_o        = r_mem_pc[r_rptr];
endmodule

// File: tb/tb_ifu_fetch_buf.sv
// Bench for ifu_fetch_buf: directed vector table, hand sequences for stall/reset corners,
// then randomized traffic checked against a queue-based reference model.
module tb_ifu_fetch_buf;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_i, redirect_i, imem_req_valid_o, imem_req_ready_i;
    logic        imem_rsp_valid_i, inst_valid_o, inst_ready_i;
    logic [31:0] redirect_pc_i, imem_req_addr_o, imem_rsp_data_i, inst_o, inst_pc_o;

    always #5 clk = ~clk;

    ifu_fetch_buf #(.XLEN(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
        .imem_req_addr_o(imem_req_addr_o), .imem_rsp_valid_i(imem_rsp_valid_i),
        .imem_rsp_data_i(imem_rsp_data_i), .inst_valid_o(inst_valid_o),
        .inst_ready_i(inst_ready_i), .inst_o(inst_o), .inst_pc_o(inst_pc_o)
    );

    typedef struct {
        logic        rst, rdr;
        logic [31:0] rpc;
        logic        rdy, rv;
        logic [31:0] rdata;
        logic        ird;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_pc, e_inst;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_err    = 0;

    function automatic vec_t mkv(input int rst, input int rdr, input logic [31:0] rpc,
                                 input int rdy, input int rv, input logic [31:0] rdata,
                                 input int ird, input int erv, input logic [31:0] eaddr,
                                 input int eiv, input logic [31:0] epc, input logic [31:0] einst);
        vec_t r;
        r.rst = (rst != 0); r.rdr = (rdr != 0); r.rpc = rpc;
        r.rdy = (rdy != 0); r.rv = (rv != 0); r.rdata = rdata; r.ird = (ird != 0);
        r.e_rv = (erv != 0); r.e_addr = eaddr; r.e_iv = (eiv != 0);
        r.e_pc = epc; r.e_inst = einst;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input string tag);
        rst_i = t.rst; redirect_i = t.rdr; redirect_pc_i = t.rpc;
        imem_req_ready_i = t.rdy; imem_rsp_valid_i = t.rv; imem_rsp_data_i = t.rdata;
        inst_ready_i = t.ird;
        @(negedge clk);
        chk({tag, " req_valid"}, 32'(imem_req_valid_o), 32'(t.e_rv));
        if (t.e_rv) chk({tag, " req_addr"}, imem_req_addr_o, t.e_addr);
        chk({tag, " inst_valid"}, 32'(inst_valid_o), 32'(t.e_iv));
        if (t.e_iv) begin
            chk({tag, " inst_pc"}, inst_pc_o, t.e_pc);
            chk({tag, " inst"}, inst_o, t.e_inst);
        end
        @(posedge clk);
        #1;
    endtask

    // Reference model: fetch pc, one in-flight flag with a "discard" mark, and a queue.
    logic [31:0] m_pc, m_pend;
    bit          m_out, m_disc;
    ent_t        m_q[$];
    bit          mem_pend;
    logic [31:0] mem_addr;
    int          mem_cnt;

    initial begin
        rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0; inst_ready_i = 1'b0;

        tbl.push_back(mkv(1,0,0,           0,0,0,           0, 0,0,           0,0,0));
        tbl.push_back(mkv(0,0,0,           1,0,0,           0, 1,32'h80000000,0,0,0));
        tbl.push_back(mkv(0,0,0,           1,1,32'h00100073,0, 0,0,           0,0,0));
        tbl.push_back(mkv(0,0,0,           0,0,0,           0, 1,32'h80000004,1,32'h80000000,32'h00100073));
        tbl.push_back(mkv(0,0,0,           1,0,0,           0, 1,32'h80000004,1,32'h80000000,32'h00100073));
        tbl.push_back(mkv(0,0,0,           1,1,32'h00000013,0, 0,0,           1,32'h80000000,32'h00100073));
        tbl.push_back(mkv(0,0,0,           1,0,0,           0, 0,0,           1,32'h80000000,32'h00100073));
        tbl.push_back(mkv(0,0,0,           1,0,0,           1, 0,0,           1,32'h80000000,32'h00100073));
        tbl.push_back(mkv(0,0,0,           1,0,0,           0, 1,32'h80000008,1,32'h80000004,32'h00000013));
        tbl.push_back(mkv(0,1,32'h80000100,1,0,0,           0, 0,0,           1,32'h80000004,32'h00000013));
        tbl.push_back(mkv(0,0,0,           1,0,0,           0, 0,0,           0,0,0));
        tbl.push_back(mkv(0,0,0,           1,1,32'hDEADBEEF,0, 0,0,           0,0,0));
        tbl.push_back(mkv(0,0,0,           1,0,0,           0, 1,32'h80000100,0,0,0));
        tbl.push_back(mkv(0,0,0,           1,1,32'h00500093,0, 0,0,           0,0,0));
        tbl.push_back(mkv(0,0,0,           0,0,0,           0, 1,32'h80000104,1,32'h80000100,32'h00500093));
        tbl.push_back(mkv(0,1,32'h80000102,0,0,0,           0, 1,32'h80000104,1,32'h80000100,32'h00500093));
        tbl.push_back(mkv(0,0,0,           1,0,0,           0, 1,32'h80000100,0,0,0));
        tbl.push_back(mkv(0,0,0,           0,1,32'h11111111,0, 0,0,           0,0,0));
        tbl.push_back(mkv(0,0,0,           1,0,0,           0, 1,32'h80000104,1,32'h80000100,32'h11111111));
        tbl.push_back(mkv(0,1,32'h80000300,1,1,32'h22222222,1, 0,0,           1,32'h80000100,32'h11111111));
        tbl.push_back(mkv(0,0,0,           0,0,0,           0, 1,32'h80000300,0,0,0));
        tbl.push_back(mkv(0,1,32'h80000400,1,0,0,           0, 1,32'h80000300,0,0,0));
        tbl.push_back(mkv(0,0,0,           1,0,0,           0, 0,0,           0,0,0));
        tbl.push_back(mkv(0,0,0,           1,1,32'h33333333,0, 0,0,           0,0,0));
        tbl.push_back(mkv(0,0,0,           0,0,0,           0, 1,32'h80000400,0,0,0));
        tbl.push_back(mkv(0,1,32'hFFFFFFFF,0,0,0,           0, 1,32'h80000400,0,0,0));
        tbl.push_back(mkv(0,0,0,           1,0,0,           0, 1,32'hFFFFFFFC,0,0,0));
        tbl.push_back(mkv(0,0,0,           0,1,32'h44444444,0, 0,0,           0,0,0));
        tbl.push_back(mkv(0,0,0,           0,0,0,           1, 1,32'h00000000,1,32'hFFFFFFFC,32'h44444444));
        tbl.push_back(mkv(0,0,0,           0,0,0,           0, 1,32'h00000000,0,0,0));

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Request stall with redirect during the stall: no response to drop.
        apply(mkv(1,0,0,0,0,0,0, 0,0,0,0,0), "stall_rst");
        for (int i = 0; i < 3; i++) apply(mkv(0,0,0,0,0,0,0, 1,RESET_PC,0,0,0), $sformatf("stall%0d", i));
        apply(mkv(0,1,32'h80000200,0,0,0,0, 1,RESET_PC,0,0,0), "stall_rdr");
        apply(mkv(0,0,0,1,0,0,0, 1,32'h80000200,0,0,0), "stall_new");
        apply(mkv(0,0,0,0,1,32'h00000297,0, 0,0,0,0,0), "stall_rsp");
        apply(mkv(0,0,0,0,0,0,0, 1,32'h80000204,1,32'h80000200,32'h00000297), "stall_out");

        // Reset while waiting with one entry queued.
        apply(mkv(1,0,0,0,0,0,0, 0,0,0,0,0), "mrst_a");
        apply(mkv(0,0,0,1,0,0,0, 1,RESET_PC,0,0,0), "mrst_b");
        apply(mkv(0,0,0,0,1,32'hAAAA0001,0, 0,0,0,0,0), "mrst_c");
        apply(mkv(0,0,0,1,0,0,0, 1,32'h80000004,1,RESET_PC,32'hAAAA0001), "mrst_d");
        apply(mkv(1,0,0,0,0,0,0, 0,0,0,0,0), "mrst_rst");
        apply(mkv(0,0,0,0,0,0,0, 1,RESET_PC,0,0,0), "mrst_after");

        m_pc = RESET_PC; m_pend = '0; m_out = 0; m_disc = 0; m_q.delete();
        mem_pend = 0; mem_addr = '0; mem_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            bit          r, e_rv, e_iv, fire, popping, rsp_done, hs;
            logic [31:0] hs_addr;
            ent_t        e;
            r = (c == 0) || ($urandom_range(0, 149) == 0);
            rst_i            = r;
            redirect_i       = !r && ($urandom_range(0, 15) == 0);
            redirect_pc_i    = $urandom;
            imem_req_ready_i = ($urandom_range(0, 3) != 0);
            imem_rsp_valid_i = !r && mem_pend && (mem_cnt == 0);
            imem_rsp_data_i  = mem_addr ^ 32'h5A5A_0F0F;
            inst_ready_i     = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            e_rv = !r && !m_out && (m_q.size() < DEPTH);
            e_iv = !r && (m_q.size() != 0);
            chk("rnd req_valid", 32'(imem_req_valid_o), 32'(e_rv));
            if (e_rv) chk("rnd req_addr", imem_req_addr_o, m_pc);
            chk("rnd inst_valid", 32'(inst_valid_o), 32'(e_iv));
            if (e_iv) begin
                chk("rnd inst_pc", inst_pc_o, m_q[0].pc);
                chk("rnd inst", inst_o, m_q[0].inst);
            end
            hs      = imem_req_valid_o && imem_req_ready_i;
            hs_addr = imem_req_addr_o;
            @(posedge clk);
            if (r) begin
                m_pc = RESET_PC; m_out = 0; m_disc = 0; m_q.delete();
                mem_pend = 0;
            end else begin
                fire     = e_rv && imem_req_ready_i;
                popping  = e_iv && inst_ready_i && !redirect_i;
                rsp_done = m_out && imem_rsp_valid_i;
                if (popping) m_q.delete(0);
                if (rsp_done && !m_disc && !redirect_i) begin
                    e.pc = m_pend; e.inst = imem_rsp_data_i;
                    m_q.push_back(e);
                end
                if (rsp_done) begin m_out = 0; m_disc = 0; end
                if (fire) begin
                    m_out = 1; m_pend = m_pc; m_disc = redirect_i;
                end else if (redirect_i && m_out) begin
                    m_disc = 1;
                end
                if (redirect_i) begin
                    m_q.delete();
                    m_pc = {redirect_pc_i[31:2], 2'b00};
                end else if (fire) begin
                    m_pc = m_pc + 32'd4;
                end
                if (imem_rsp_valid_i) mem_pend = 0;
                else if (mem_pend && mem_cnt != 0) mem_cnt--;
                if (hs) begin
                    mem_pend = 1; mem_addr = hs_addr; mem_cnt = $urandom_range(0, 2);
                end
            end
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
